// File: rtl/prog_mem_loader.sv
// Framed byte-stream loader for the 14-bit program memory: parses SYNC/count/word-pairs/checksum,
// issues sequential writes from address 0 and holds the CPU in reset while a download is open or failed.
module prog_mem_loader #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned TIMEOUT = 50_000_000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic              busy
);

  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam int unsigned MAX_N = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, W_LO, W_HI, CHK} state_e;

  state_e            state_q;
  logic              in_ready_q, wr_en_q, hold_q, done_q, error_q, busy_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [7:0]        sum_q, cnt_lo_q, lo_q;
  logic [ADDR_W:0]   n_q, wcnt_q;
  logic [TW-1:0]     tcnt_q;

  logic              hs;
  logic [7:0]        sum_d;
  logic [11:0]       n_raw;
  logic              n_bad;
  logic [ADDR_W:0]   wcnt_d;

  always_comb begin
    hs     = in_valid && in_ready_q;
    sum_d  = sum_q + in_data;
    n_raw  = {in_data[3:0], cnt_lo_q};
    n_bad  = (in_data[7:4] != 4'h0) || (n_raw == 12'd0) || (32'(n_raw) > MAX_N);
    wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      sum_q      <= '0;
      cnt_lo_q   <= '0;
      lo_q       <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      if (state_q != IDLE) begin
        tcnt_q <= hs ? '0 : tcnt_q + 1'b1;
      end
      // Inter-byte stall inside a frame aborts it like any other framing error.
      if (state_q != IDLE && !hs && tcnt_q == T_LAST) begin
        error_q <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else if (hs) begin
        case (state_q)
          IDLE: begin
            if (in_data == SYNC) begin
              state_q <= CNT_LO;
              busy_q  <= 1'b1;
              error_q <= 1'b0;
              hold_q  <= 1'b1;
              sum_q   <= '0;
              wcnt_q  <= '0;
              tcnt_q  <= '0;
            end
          end
          CNT_LO: begin
            cnt_lo_q <= in_data;
            sum_q    <= sum_d;
            state_q  <= CNT_HI;
          end
          CNT_HI: begin
            sum_q <= sum_d;
            if (n_bad) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              n_q     <= (ADDR_W + 1)'(n_raw);
              state_q <= W_LO;
            end
          end
          W_LO: begin
            lo_q    <= in_data;
            sum_q   <= sum_d;
            state_q <= W_HI;
          end
          W_HI: begin
            sum_q <= sum_d;
            if (in_data[7:6] != 2'b00) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wcnt_q[ADDR_W-1:0];
              wr_data_q <= DATA_W'({in_data[5:0], lo_q});
              wcnt_q    <= wcnt_d;
              state_q   <= (wcnt_d == n_q) ? CHK : W_LO;
            end
          end
          CHK: begin
            sum_q   <= sum_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (sum_d == 8'h00) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = error_q;
  assign busy     = busy_q;

endmodule
